systolic_array_sequencer: RTL and testbench

//  Avalon-MM controller that runs the systolic array as a Nios peripheral. The CPU sets source and

---
 rtl/systolic_array_sequencer.sv | 256 +++++++++++++++++++++++++
 tb/tb_systolic_array_sequencer.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/systolic_array_sequencer.sv
// Avalon-MM sequencer: fetches A and B from SDRAM into the systolic array, starts it, writes results back.
// Optional cycle counter on CSR 6 is built when SEQ_PERF_CNT_EN is defined.
module systolic_array_sequencer #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int MAX_N  = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [2:0]        avs_address,
    input  logic              avs_read,
    input  logic              avs_write,
    input  logic [31:0]       avs_writedata,
    output logic [31:0]       avs_readdata,
    output logic [ADDR_W-1:0] avm_address,
    output logic              avm_read,
    output logic              avm_write,
    output logic [DATA_W-1:0] avm_writedata,
    input  logic              avm_waitrequest,
    input  logic [DATA_W-1:0] avm_readdata,
    input  logic              avm_readdatavalid,
    output logic              arr_load_valid,
    output logic              arr_load_sel,
    output logic [DATA_W-1:0] arr_load_data,
    output logic              arr_start,
    input  logic              arr_done,
    input  logic              arr_res_valid,
    input  logic [DATA_W-1:0] arr_res_data,
    output logic              arr_res_ready,
    output logic              irq
);

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_FETCH_A = 3'd1;
    localparam logic [2:0] ST_FETCH_B = 3'd2;
    localparam logic [2:0] ST_START   = 3'd3;
    localparam logic [2:0] ST_WAIT    = 3'd4;
    localparam logic [2:0] ST_DRAIN   = 3'd5;

    localparam logic [3:0] MAX_N4 = 4'(MAX_N);

    logic [2:0]        state;
    logic              irq_en;
    logic              busy;
    logic              done;
    logic              err;
    logic [ADDR_W-1:0] src_a;
    logic [ADDR_W-1:0] src_b;
    logic [ADDR_W-1:0] dst;
    logic [3:0]        size;
    logic [ADDR_W-1:0] job_src_a;
    logic [ADDR_W-1:0] job_src_b;
    logic [ADDR_W-1:0] job_dst;
    logic [6:0]        job_words;
    logic [6:0]        idx;
    logic              rd_outstanding;
    logic              drop_rsp;
    logic              abort_pend;
    logic [31:0]       cycles;

    logic wr_ctrl;
    logic go_req;
    logic abort_req;
    logic size_ok;
    logic in_fetch;
    logic rsp_fire;
    logic res_fire;
    logic last_word;
    logic [6:0] size_w;

    wire unused_wdata = &{1'b0, avs_writedata[31:4]};

    function automatic logic [ADDR_W-1:0] word_addr(input logic [ADDR_W-1:0] base,
                                                    input logic [6:0] i);
        return base + (ADDR_W'(i) << 2);
    endfunction

    assign wr_ctrl   = avs_write && (avs_address == 3'd0);
    assign go_req    = wr_ctrl && avs_writedata[0];
    assign abort_req = wr_ctrl && avs_writedata[2];
    assign size_ok   = (size != 4'd0) && (size <= MAX_N4);
    assign size_w    = {3'd0, size};
    assign in_fetch  = (state == ST_FETCH_A) || (state == ST_FETCH_B);
    assign rsp_fire  = avm_readdatavalid && rd_outstanding;
    assign last_word = (idx == job_words - 7'd1);

    assign arr_load_valid = in_fetch && rsp_fire && !abort_pend;
    assign arr_load_sel   = (state == ST_FETCH_B);
    assign arr_load_data  = arr_load_valid ? avm_readdata : '0;
    assign arr_start      = (state == ST_START);
    assign arr_res_ready  = (state == ST_DRAIN) && !avm_write && !abort_pend;
    assign res_fire       = arr_res_valid && arr_res_ready;
    assign irq            = done && irq_en;

    // Job sequencing and status; later assignments to done/err take priority over the W1C clears
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= ST_IDLE;
            busy           <= 1'b0;
            done           <= 1'b0;
            err            <= 1'b0;
            job_src_a      <= '0;
            job_src_b      <= '0;
            job_dst        <= '0;
            job_words      <= '0;
            idx            <= '0;
            rd_outstanding <= 1'b0;
            drop_rsp       <= 1'b0;
            abort_pend     <= 1'b0;
            avm_address    <= '0;
            avm_read       <= 1'b0;
            avm_write      <= 1'b0;
            avm_writedata  <= '0;
        end else begin
            if (avs_write && (avs_address == 3'd1)) begin
                if (avs_writedata[1]) done <= 1'b0;
                if (avs_writedata[2]) err  <= 1'b0;
            end
            if (abort_req && busy) abort_pend <= 1'b1;
            if (avm_readdatavalid && drop_rsp) drop_rsp <= 1'b0;

            case (state)
                ST_IDLE: begin
                    abort_pend <= 1'b0;
                    if (go_req) begin
                        if (!size_ok) begin
                            err <= 1'b1;
                        end else begin
                            job_src_a <= src_a;
                            job_src_b <= src_b;
                            job_dst   <= dst;
                            job_words <= size_w * size_w;
                            idx       <= '0;
                            busy      <= 1'b1;
                            done      <= 1'b0;
                            state     <= ST_FETCH_A;
                        end
                    end
                end
                default: begin
                    if (abort_pend) begin
                        // Let a stalled request finish its handshake before giving up the bus
                        if (!((avm_read || avm_write) && avm_waitrequest)) begin
                            drop_rsp       <= avm_read || (rd_outstanding && !avm_readdatavalid);
                            avm_read       <= 1'b0;
                            avm_write      <= 1'b0;
                            rd_outstanding <= 1'b0;
                            abort_pend     <= 1'b0;
                            busy           <= 1'b0;
                            err            <= 1'b1;
                            done           <= 1'b0;
                            idx            <= '0;
                            state          <= ST_IDLE;
                        end
                    end else begin
                        case (state)
                            ST_FETCH_A, ST_FETCH_B: begin
                                if (avm_read && !avm_waitrequest) begin
                                    avm_read       <= 1'b0;
                                    rd_outstanding <= 1'b1;
                                end else if (!avm_read && !rd_outstanding && !drop_rsp) begin
                                    avm_read    <= 1'b1;
                                    avm_address <= word_addr((state == ST_FETCH_A) ? job_src_a
                                                                                   : job_src_b, idx);
                                end
                                if (rsp_fire) begin
                                    rd_outstanding <= 1'b0;
                                    if (last_word) begin
                                        idx   <= '0;
                                        state <= (state == ST_FETCH_A) ? ST_FETCH_B : ST_START;
                                    end else begin
                                        idx <= idx + 7'd1;
                                    end
                                end
                            end
                            ST_START: state <= ST_WAIT;
                            ST_WAIT: begin
                                if (arr_done) state <= ST_DRAIN;
                            end
                            ST_DRAIN: begin
                                if (res_fire) begin
                                    avm_write     <= 1'b1;
                                    avm_writedata <= arr_res_data;
                                    avm_address   <= word_addr(job_dst, idx);
                                end else if (avm_write && !avm_waitrequest) begin
                                    avm_write <= 1'b0;
                                    if (last_word) begin
                                        idx   <= '0;
                                        busy  <= 1'b0;
                                        done  <= 1'b1;
                                        state <= ST_IDLE;
                                    end else begin
                                        idx <= idx + 7'd1;
                                    end
                                end
                            end
                            default: state <= ST_IDLE;
                        endcase
                    end
                end
            endcase
        end
    end

    // Software-visible configuration; the running job works from its own latched copies
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irq_en <= 1'b0;
            src_a  <= '0;
            src_b  <= '0;
            dst    <= '0;
            size   <= '0;
        end else if (avs_write) begin
            case (avs_address)
                3'd0: irq_en <= avs_writedata[1];
                3'd2: src_a  <= ADDR_W'(avs_writedata);
                3'd3: src_b  <= ADDR_W'(avs_writedata);
                3'd4: dst    <= ADDR_W'(avs_writedata);
                3'd5: size   <= avs_writedata[3:0];
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            avs_readdata <= '0;
        end else if (avs_read) begin
            case (avs_address)
                3'd0:    avs_readdata <= {30'd0, irq_en, 1'b0};
                3'd1:    avs_readdata <= {29'd0, err, done, busy};
                3'd2:    avs_readdata <= 32'(src_a);
                3'd3:    avs_readdata <= 32'(src_b);
                3'd4:    avs_readdata <= 32'(dst);
                3'd5:    avs_readdata <= {28'd0, size};
                3'd6:    avs_readdata <= cycles;
                default: avs_readdata <= '0;
            endcase
        end
    end

`ifdef SEQ_PERF_CNT_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cycles <= '0;
        end else if ((state == ST_IDLE) && go_req && size_ok) begin
            cycles <= '0;
        end else if (busy && (cycles != 32'hFFFF_FFFF)) begin
            cycles <= cycles + 32'd1;
        end
    end
`else
    assign cycles = 32'd0;
`endif

endmodule

// File: tb/tb_systolic_array_sequencer.sv
// Directed bench for systolic_array_sequencer with SDRAM slave and systolic array models.
module tb_systolic_array_sequencer;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [2:0]  avs_address = '0;
    logic        avs_read = 1'b0;
    logic        avs_write = 1'b0;
    logic [31:0] avs_writedata = '0;
    logic [31:0] avs_readdata;
    logic [31:0] avm_address;
    logic        avm_read;
    logic        avm_write;
    logic [31:0] avm_writedata;
    logic        avm_waitrequest = 1'b0;
    logic [31:0] avm_readdata = '0;
    logic        avm_readdatavalid = 1'b0;
    logic        arr_load_valid;
    logic        arr_load_sel;
    logic [31:0] arr_load_data;
    logic        arr_start;
    logic        arr_done = 1'b0;
    logic        arr_res_valid = 1'b0;
    logic [31:0] arr_res_data = '0;
    logic        arr_res_ready;
    logic        irq;

    always #5 clk = ~clk;

    systolic_array_sequencer dut (
        .clk(clk), .reset_n(reset_n),
        .avs_address(avs_address), .avs_read(avs_read), .avs_write(avs_write),
        .avs_writedata(avs_writedata), .avs_readdata(avs_readdata),
        .avm_address(avm_address), .avm_read(avm_read), .avm_write(avm_write),
        .avm_writedata(avm_writedata), .avm_waitrequest(avm_waitrequest),
        .avm_readdata(avm_readdata), .avm_readdatavalid(avm_readdatavalid),
        .arr_load_valid(arr_load_valid), .arr_load_sel(arr_load_sel),
        .arr_load_data(arr_load_data), .arr_start(arr_start), .arr_done(arr_done),
        .arr_res_valid(arr_res_valid), .arr_res_data(arr_res_data),
        .arr_res_ready(arr_res_ready), .irq(irq)
    );

    int checks = 0;
    int errors = 0;

    logic [31:0] mem [0:1023];
    logic [32:0] load_q [$];
    logic [31:0] wr_addr_q [$];
    logic [31:0] wr_data_q [$];
    int          cyc = 0;
    int          start_cnt = 0;
    int          act_cnt = 0;
    int          viol_cnt = 0;
    int          outstanding = 0;
    int          go_cyc = 0;
    int          last_acc_cyc = 0;
    logic        prev_stall = 1'b0;
    logic [31:0] prev_addr = '0;
    logic        rd_busy = 1'b0;
    int          rd_lat = 0;
    logic [31:0] rd_addr = '0;
    logic        start_seen = 1'b0;
    int          done_cnt = 0;
    int          done_delay = 3;
    int          res_idx = 0;
    logic [31:0] res_base = 32'hC000_0000;
    bit          wr_rand = 1'b0;
    bit          wr_force = 1'b0;
    bit          lat_rand = 1'b0;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Observe every handshake on the edge the DUT sees it
    always @(posedge clk) begin
        cyc++;
        if (reset_n) begin
            if (avm_read || avm_write || arr_load_valid || arr_start) act_cnt++;
            if (prev_stall && !(avm_read && avm_address == prev_addr)) viol_cnt++;
            prev_stall = avm_read && avm_waitrequest;
            prev_addr  = avm_address;
            if (avm_readdatavalid) outstanding--;
            if (avm_read && !avm_waitrequest) begin
                if (outstanding != 0) viol_cnt++;
                outstanding++;
                rd_addr = avm_address;
                rd_lat  = lat_rand ? int'($urandom_range(1, 5)) : 1;
                rd_busy = 1'b1;
            end
            if (avm_write && !avm_waitrequest) begin
                wr_addr_q.push_back(avm_address);
                wr_data_q.push_back(avm_writedata);
                last_acc_cyc = cyc;
            end
            if (arr_res_ready && avm_write) viol_cnt++;
            if (arr_load_valid) load_q.push_back({arr_load_sel, arr_load_data});
            if (arr_start) begin
                start_cnt++;
                start_seen = 1'b1;
            end
            if (arr_res_valid && arr_res_ready) res_idx++;
            if (avs_write && avs_address == 3'd0 && avs_writedata[0]) go_cyc = cyc;
        end
    end

    always @(negedge clk) begin
        avm_waitrequest   = wr_force | (wr_rand & ($urandom_range(0, 1) == 1));
        avm_readdatavalid = 1'b0;
        if (rd_busy) begin
            rd_lat--;
            if (rd_lat == 0) begin
                avm_readdatavalid = 1'b1;
                avm_readdata      = mem[rd_addr[11:2]];
                rd_busy           = 1'b0;
            end
        end
        if (start_seen) begin
            arr_done   = 1'b0;
            done_cnt   = done_delay;
            start_seen = 1'b0;
            res_idx    = 0;
        end else if (done_cnt > 0) begin
            done_cnt--;
            if (done_cnt == 0) arr_done = 1'b1;
        end
        arr_res_valid = arr_done;
        arr_res_data  = res_base + 32'(res_idx);
    end

    task automatic csrWrite(input logic [2:0] a, input logic [31:0] d);
        avs_address = a; avs_writedata = d; avs_write = 1'b1;
        @(negedge clk);
        avs_write = 1'b0;
    endtask

    task automatic csrRead(input logic [2:0] a, output logic [31:0] d);
        avs_address = a; avs_read = 1'b1;
        @(negedge clk);
        avs_read = 1'b0;
        d = avs_readdata;
    endtask

    task automatic applyStimulus(input int n, input logic [31:0] sa, input logic [31:0] sb,
                                 input logic [31:0] d);
        csrWrite(3'd2, sa);
        csrWrite(3'd3, sb);
        csrWrite(3'd4, d);
        csrWrite(3'd5, 32'(n));
        csrWrite(3'd0, 32'h3);
    endtask

    task automatic waitIdle(input string tag, input int limit);
        logic [31:0] s;
        int n = 0;
        do begin
            csrRead(3'd1, s);
            n++;
        end while (s[0] && n < limit);
        checkOutput({tag, "_idle"}, s[0], 0);
    endtask

    task automatic clearQueues();
        load_q.delete(); wr_addr_q.delete(); wr_data_q.delete();
        start_cnt = 0; act_cnt = 0;
    endtask

    task automatic checkLoads(input string tag, input int n, input logic [31:0] sa,
                              input logic [31:0] sb);
        int w = n * n;
        checkOutput({tag, "_load_count"}, load_q.size(), 2 * w);
        if (load_q.size() == 2 * w) begin
            for (int i = 0; i < w; i++) begin
                checkOutput($sformatf("%s_a%0d", tag, i), load_q[i], {1'b0, mem[(sa >> 2) + i]});
                checkOutput($sformatf("%s_b%0d", tag, i), load_q[w + i], {1'b1, mem[(sb >> 2) + i]});
            end
        end
    endtask

    task automatic checkWrites(input string tag, input int n, input logic [31:0] d,
                               input logic [31:0] rb);
        int w = n * n;
        checkOutput({tag, "_wr_count"}, wr_addr_q.size(), w);
        if (wr_addr_q.size() == w) begin
            for (int i = 0; i < w; i++) begin
                checkOutput($sformatf("%s_waddr%0d", tag, i), wr_addr_q[i], d + 32'(4 * i));
                checkOutput($sformatf("%s_wdata%0d", tag, i), wr_data_q[i], rb + 32'(i));
            end
        end
    endtask

    initial begin
        #900000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [31:0] s;
        int n;
        for (int i = 0; i < 1024; i++) mem[i] = 32'h1000_0000 + 32'(i * 7);

        repeat (3) @(negedge clk);
        checkOutput("reset_outputs",
                    {avm_read, avm_write, irq, arr_start, arr_res_ready, arr_load_valid, arr_load_sel}, 0);
        checkOutput("reset_addr", avm_address, 0);
        reset_n = 1'b1;
        @(negedge clk);
        csrRead(3'd1, s); checkOutput("reset_status", s, 0);
        csrRead(3'd2, s); checkOutput("reset_src_a", s, 0);

        // Basic 2x2 job
        clearQueues();
        applyStimulus(2, 32'h100, 32'h200, 32'h300);
        waitIdle("basic", 500);
        checkLoads("basic", 2, 32'h100, 32'h200);
        checkWrites("basic", 2, 32'h300, 32'hC000_0000);
        checkOutput("basic_starts", start_cnt, 1);
        csrRead(3'd1, s); checkOutput("basic_status", s[2:0], 3'b010);
        checkOutput("basic_irq", irq, 1);
        csrRead(3'd2, s); checkOutput("csr_src_a", s, 32'h100);
        csrRead(3'd5, s); checkOutput("csr_size", s, 2);
        csrRead(3'd0, s); checkOutput("csr_ctrl", s, 2);
        csrRead(3'd7, s); checkOutput("csr_unmapped", s, 0);
        csrWrite(3'd1, 32'h2);
        @(negedge clk);
        checkOutput("irq_cleared", irq, 0);

        // 8x8 job with random stalls and read latency
        clearQueues();
        wr_rand = 1'b1; lat_rand = 1'b1; res_base = 32'hD000_0000;
        applyStimulus(8, 32'h400, 32'h600, 32'h800);
        waitIdle("rand", 6000);
        wr_rand = 1'b0; lat_rand = 1'b0;
        repeat (2) @(negedge clk);
        checkLoads("rand", 8, 32'h400, 32'h600);
        checkWrites("rand", 8, 32'h800, 32'hD000_0000);
        checkOutput("rand_protocol", viol_cnt, 0);
        csrWrite(3'd1, 32'h2);

        // Illegal sizes
        clearQueues();
        csrWrite(3'd5, 32'd0);
        csrWrite(3'd0, 32'h3);
        repeat (5) @(negedge clk);
        csrRead(3'd1, s); checkOutput("size0_status", s[2:0], 3'b100);
        checkOutput("size0_activity", act_cnt, 0);
        csrWrite(3'd1, 32'h4);
        csrWrite(3'd5, 32'd9);
        csrWrite(3'd0, 32'h3);
        repeat (5) @(negedge clk);
        csrRead(3'd1, s); checkOutput("size9_status", s[2:0], 3'b100);
        checkOutput("size9_activity", act_cnt, 0);
        csrWrite(3'd1, 32'h4);

        // Abort during FETCH_B with the first B read stalled
        clearQueues();
        res_base = 32'hC000_0000;
        applyStimulus(2, 32'h100, 32'h200, 32'h300);
        for (n = 0; n < 200 && load_q.size() < 4; n++) @(negedge clk);
        wr_force = 1'b1; avm_waitrequest = 1'b1;
        for (n = 0; n < 50 && !(avm_read && avm_address == 32'h200); n++) @(negedge clk);
        checkOutput("abort_read_seen", avm_read, 1);
        csrWrite(3'd0, 32'h6);
        repeat (4) @(negedge clk);
        checkOutput("abort_read_held", {avm_read, avm_address}, {1'b1, 32'h200});
        csrRead(3'd1, s); checkOutput("abort_still_busy", s[0], 1);
        wr_force = 1'b0; avm_waitrequest = 1'b0;
        waitIdle("abort", 100);
        repeat (6) @(negedge clk);
        csrRead(3'd1, s); checkOutput("abort_status", s[2:0], 3'b100);
        checkOutput("abort_loads", load_q.size(), 4);
        checkOutput("abort_starts", start_cnt, 0);
        csrWrite(3'd1, 32'h4);
        clearQueues();
        applyStimulus(1, 32'h100, 32'h200, 32'h300);
        waitIdle("post_abort", 200);
        checkLoads("post_abort", 1, 32'h100, 32'h200);
        checkWrites("post_abort", 1, 32'h300, 32'hC000_0000);
        csrRead(3'd1, s); checkOutput("post_abort_status", s[2:0], 3'b010);
        csrWrite(3'd1, 32'h2);

        // GO and DST rewrite while busy, DONE clear colliding with the final write
        clearQueues();
        done_delay = 20; res_base = 32'hE000_0000;
        applyStimulus(2, 32'h100, 32'h200, 32'h300);
        for (n = 0; n < 200 && start_cnt == 0; n++) @(negedge clk);
        csrWrite(3'd4, 32'h700);
        csrWrite(3'd0, 32'h3);
        wr_force = 1'b1; avm_waitrequest = 1'b1;
        for (int w = 0; w < 4; w++) begin
            for (n = 0; n < 100 && !avm_write; n++) @(negedge clk);
            wr_force = 1'b0; avm_waitrequest = 1'b0;
            if (w == 3) begin
                avs_address = 3'd1; avs_writedata = 32'h2; avs_write = 1'b1;
            end
            @(negedge clk);
            avs_write = 1'b0;
            wr_force = 1'b1; avm_waitrequest = 1'b1;
        end
        wr_force = 1'b0; avm_waitrequest = 1'b0;
        waitIdle("collide", 200);
        repeat (10) @(negedge clk);
        csrRead(3'd1, s); checkOutput("collide_status", s[2:0], 3'b010);
        checkWrites("collide", 2, 32'h300, 32'hE000_0000);
        checkOutput("collide_starts", start_cnt, 1);
        checkOutput("collide_loads", load_q.size(), 8);
        csrRead(3'd4, s); checkOutput("collide_dst_csr", s, 32'h700);
        csrWrite(3'd1, 32'h2);

        // Cycle counter
        clearQueues();
        done_delay = 10;
        applyStimulus(1, 32'h100, 32'h200, 32'h300);
        waitIdle("perf", 300);
        csrRead(3'd6, s);
`ifdef SEQ_PERF_CNT_EN
        checkOutput("perf_cycles", s, 32'(last_acc_cyc - go_cyc));
`else
        checkOutput("perf_absent", s, 0);
`endif
        checkOutput("final_protocol", viol_cnt, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
